// File: rtl/aes_channel_arbiter.sv
// rtl/aes_channel_arbiter.sv - round-robin arbiter sharing one AES encryptor among NUM_CH channels
// A grant is taken in IDLE, the key/sync is handed over in LOAD_KEY, and the packet streams in STREAM.
module aes_channel_arbiter #(
    parameter int NUM_CH              = 4,
    parameter int DATA_WIDTH_IN_BYTES = 16,
    parameter int CH_ID_W             = $clog2(NUM_CH),
    localparam int W                  = 8 * DATA_WIDTH_IN_BYTES,
    localparam int CH_EMPTY_W         = $clog2(DATA_WIDTH_IN_BYTES)
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic [NUM_CH-1:0]            ch_key_valid,
    input  logic [NUM_CH*W-1:0]          ch_key,
    input  logic [NUM_CH*W-1:0]          ch_sync,
    output logic [NUM_CH-1:0]            ch_key_rdy,

    input  logic [NUM_CH-1:0]            ch_valid,
    input  logic [NUM_CH*W-1:0]          ch_data,
    input  logic [NUM_CH-1:0]            ch_sop,
    input  logic [NUM_CH-1:0]            ch_eop,
    input  logic [NUM_CH*CH_EMPTY_W-1:0] ch_empty,
    output logic [NUM_CH-1:0]            ch_rdy,

    output logic                         enc_key_valid,
    output logic [W-1:0]                 enc_key,
    output logic [W-1:0]                 enc_sync,
    input  logic                         enc_key_rdy,

    output logic                         enc_valid,
    output logic [W-1:0]                 enc_data,
    output logic                         enc_sop,
    output logic                         enc_eop,
    output logic [CH_EMPTY_W-1:0]        enc_empty,
    input  logic                         enc_rdy,

    output logic [CH_ID_W-1:0]           grant_id,
    output logic                         busy
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD_KEY = 2'd1,
        STREAM   = 2'd2
    } state_t;

    state_t               state;
    logic [CH_ID_W-1:0]   last_grant;
    logic [CH_ID_W-1:0]   rr_pick;
    logic                 eop_beat;

    // Search order starts just after the previous winner so every channel gets a turn.
    always_comb begin
        int  idx;
        logic found;
        rr_pick = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= NUM_CH; k++) begin
            idx = int'(last_grant) + k;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!found && ch_key_valid[idx[CH_ID_W-1:0]]) begin
                found   = 1'b1;
                rr_pick = idx[CH_ID_W-1:0];
            end
        end
    end

    assign eop_beat = ch_valid[grant_id] && enc_rdy && ch_eop[grant_id];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            grant_id   <= '0;
            last_grant <= CH_ID_W'(NUM_CH - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|ch_key_valid) begin
                        grant_id <= rr_pick;
                        state    <= LOAD_KEY;
                        busy     <= 1'b1;
                    end
                end
                LOAD_KEY: begin
                    // The request line may drop here; the key stays offered until taken.
                    if (enc_key_rdy) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (eop_beat) begin
                        last_grant <= grant_id;
                        state      <= IDLE;
                        busy       <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign enc_key_valid = (state == LOAD_KEY);
    assign enc_key       = ch_key[int'(grant_id) * W +: W];
    assign enc_sync      = ch_sync[int'(grant_id) * W +: W];

    assign enc_valid     = (state == STREAM) && ch_valid[grant_id];
    assign enc_data      = ch_data[int'(grant_id) * W +: W];
    assign enc_sop       = ch_sop[grant_id];
    assign enc_eop       = ch_eop[grant_id];
    assign enc_empty     = ch_empty[int'(grant_id) * CH_EMPTY_W +: CH_EMPTY_W];

    always_comb begin
        ch_key_rdy = '0;
        ch_rdy     = '0;
        if (state == LOAD_KEY && enc_key_rdy) begin
            ch_key_rdy[grant_id] = 1'b1;
        end
        if (state == STREAM) begin
            ch_rdy[grant_id] = enc_rdy;
        end
    end

endmodule
